// File: rtl/run_monitor_if.sv
// run_monitor_if: instruction-snoop, register-read and dump-stream signals of run_monitor.
interface run_monitor_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) ();
    logic              inst_valid;
    logic [DATA_W-1:0] inst_word;
    logic [REG_AW-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [REG_AW-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;

    modport master (
        input  inst_valid, inst_word, reg_data, dump_ready,
        output reg_addr, dump_valid, dump_idx, dump_data
    );

    modport slave (
        output inst_valid, inst_word, reg_data, dump_ready,
        input  reg_addr, dump_valid, dump_idx, dump_data
    );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: times a program run until HALT_WORD or TIMEOUT, then streams a register dump.
module run_monitor #(
    parameter int                DATA_W    = 32,
    parameter int                REG_AW    = 5,
    parameter int                DUMP_N    = 10,
    parameter int                TIMEOUT   = 500,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int                CNT_W     = 32
) (
    input  logic             CLOCK_50,
    input  logic             RSTN_N,
    input  logic             start,
    run_monitor_if.master    bus,
    output logic [CNT_W-1:0] clk_cnt,
    output logic             busy,
    output logic             done,
    output logic             halt_seen,
    output logic             timed_out
);
    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

    state_t            state, state_nx;
    logic [REG_AW-1:0] idx_q;
    logic [DATA_W-1:0] data_q;
    logic              halt, tmo, last, accept;

    assign halt   = bus.inst_valid && bus.inst_word == HALT_WORD;
    assign tmo    = clk_cnt == CNT_W'(TIMEOUT - 1);
    assign last   = idx_q == REG_AW'(DUMP_N - 1);
    assign accept = state == DUMP && bus.dump_ready;

    // reg_addr runs one index ahead so dump_data can reload every accepted cycle
    assign bus.reg_addr   = state == DUMP ? idx_q + 1'b1 : '0;
    assign bus.dump_valid = state == DUMP;
    assign bus.dump_idx   = idx_q;
    assign bus.dump_data  = data_q;
    assign busy           = state == RUN || state == DUMP;
    assign done           = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? RUN : state;
            RUN:        state_nx = halt || tmo ? DUMP : RUN;
            DUMP:       state_nx = accept && last ? DONE : DUMP;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            halt_seen <= 1'b0;
            timed_out <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: if (start) begin
                    clk_cnt   <= '0;
                    halt_seen <= 1'b0;
                    timed_out <= 1'b0;
                    idx_q     <= '0;
                end
                RUN: begin
                    if (~&clk_cnt) clk_cnt <= clk_cnt + 1'b1;
                    if (halt) halt_seen <= 1'b1;
                    else if (tmo) timed_out <= 1'b1;
                    if (halt || tmo) data_q <= bus.reg_data;
                end
                DUMP: if (accept && !last) begin
                    idx_q  <= idx_q + 1'b1;
                    data_q <= bus.reg_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed checks of run_monitor run timing, halt/timeout, dump stream and reset.
module tb_run_monitor;
    localparam int          DUMP_N = 10;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic        CLOCK_50 = 1'b0;
    logic        RSTN_N   = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] clk_cnt;
    logic        busy, done, halt_seen, timed_out;
    int          tests = 0;
    int          fails = 0;
    int          cyc;

    run_monitor_if #(.DATA_W(32), .REG_AW(5)) bus ();

    run_monitor dut (
        .CLOCK_50 (CLOCK_50),
        .RSTN_N   (RSTN_N),
        .start    (start),
        .bus      (bus),
        .clk_cnt  (clk_cnt),
        .busy     (busy),
        .done     (done),
        .halt_seen(halt_seen),
        .timed_out(timed_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] rv(input int i);
        return 32'h5A00_0007 ^ (i * 32'h0001_1111);
    endfunction

    assign bus.reg_data = rv(int'(bus.reg_addr));

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drains the dump; stalled cycles must keep showing the same expected word
    task automatic drain(input logic [3:0] pat, output int cycles);
        int e = 0;
        cycles = 0;
        while (e < DUMP_N && cycles < 200) begin
            bus.dump_ready = pat[cycles % 4];
            chk("dump_valid", bus.dump_valid, 1);
            chk("dump_idx", bus.dump_idx, e);
            chk("dump_data", bus.dump_data, rv(e));
            chk("reg_addr_dump", bus.reg_addr, e + 1);
            if (bus.dump_ready) e++;
            tick();
            cycles++;
        end
        bus.dump_ready = 1'b0;
        chk("drain_words", e, DUMP_N);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inst_valid = 1'b0;
        bus.inst_word  = '0;
        bus.dump_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dump_valid", bus.dump_valid, 0);
        chk("rst_clk_cnt", clk_cnt, 0);
        chk("rst_reg_addr", bus.reg_addr, 0);
        chk("rst_dump_data", bus.dump_data, 0);
        bus.dump_ready = 1'b1;
        tick();
        chk("ready_idle_no_effect", bus.dump_valid, 0);
        bus.dump_ready = 1'b0;
        RSTN_N = 1'b1;

        // Halt on run cycle 20, with a masked HALT_WORD earlier
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_clk_cnt0", clk_cnt, 0);
        chk("run_reg_addr", bus.reg_addr, 0);
        for (int i = 0; i < 20; i++) begin
            bus.inst_valid = (i == 5);
            bus.inst_word  = (i == 5) ? 32'h13 : (i == 10) ? HALT : 32'(i);
            tick();
        end
        chk("pre_halt_busy", bus.dump_valid, 0);
        chk("pre_halt_cnt", clk_cnt, 20);
        bus.inst_valid = 1'b1;
        bus.inst_word  = HALT;
        tick();
        bus.inst_valid = 1'b0;
        chk("h_halt_seen", halt_seen, 1);
        chk("h_timed_out", timed_out, 0);
        chk("h_clk_cnt", clk_cnt, 21);
        drain(4'b1111, cyc);
        chk("h_drain_cycles", cyc, 10);
        chk("h_done", done, 1);
        chk("h_busy", busy, 0);
        chk("h_dv_off", bus.dump_valid, 0);
        chk("h_cnt_frozen", clk_cnt, 21);
        chk("h_flag_hold", halt_seen, 1);

        // Restart from DONE, ignored start in RUN, then timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t_cnt_clr", clk_cnt, 0);
        chk("t_halt_clr", halt_seen, 0);
        chk("t_done_clr", done, 0);
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t_start_in_run", clk_cnt, 4);
        cyc = 0;
        while (!bus.dump_valid && cyc < 600) begin
            tick();
            cyc++;
        end
        chk("t_clk_cnt", clk_cnt, 500);
        chk("t_timed_out", timed_out, 1);
        chk("t_halt_seen", halt_seen, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t_start_in_dump_idx", bus.dump_idx, 0);
        chk("t_start_in_dump_cnt", clk_cnt, 500);
        drain(4'b1001, cyc);
        chk("t_done", done, 1);
        chk("t_flag_hold", timed_out, 1);

        // Halt coinciding with the timeout cycle, then reset mid-dump
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (clk_cnt != 499 && cyc < 600) begin
            tick();
            cyc++;
        end
        chk("c_at_499", clk_cnt, 499);
        bus.inst_valid = 1'b1;
        bus.inst_word  = HALT;
        tick();
        bus.inst_valid = 1'b0;
        chk("c_halt_seen", halt_seen, 1);
        chk("c_timed_out", timed_out, 0);
        chk("c_clk_cnt", clk_cnt, 500);
        bus.dump_ready = 1'b1;
        repeat (4) tick();
        bus.dump_ready = 1'b0;
        chk("c_idx4", bus.dump_idx, 4);
        chk("c_data4", bus.dump_data, rv(4));
        #2 RSTN_N = 1'b0;
        #1;
        chk("r_dump_valid", bus.dump_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_halt", halt_seen, 0);
        chk("r_cnt", clk_cnt, 0);
        chk("r_idx", bus.dump_idx, 0);
        chk("r_data", bus.dump_data, 0);
        tick();
        RSTN_N = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("r_restart_busy", busy, 1);
        chk("r_restart_cnt", clk_cnt, 0);
        tick();
        tick();
        tick();
        bus.inst_valid = 1'b1;
        bus.inst_word  = HALT;
        tick();
        bus.inst_valid = 1'b0;
        chk("r_halt_cnt", clk_cnt, 4);
        drain(4'b1111, cyc);
        chk("r_drain_cycles", cyc, 10);
        chk("r_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter DATA_W, 32, width of instruction and register words.
REQ-002 Parameter REG_AW, 5, register index width.
REQ-003 Parameter DUMP_N, 10, number of registers dumped (1..2**REG_AW).
REQ-004 Parameter TIMEOUT, 500, run-cycle budget (>=1).
REQ-005 Parameter HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends a run.
REQ-006 Parameter CNT_W, 32, cycle counter width.
REQ-007 Clocking: one clock; reset is asynchronous and active-low.
REQ-008 CLOCK_50  in  1  sole clock, rising edge.
REQ-009 RSTN_N  in  1  asynchronous active-low reset.
REQ-010 start  in  1  single-cycle request to begin a run.
REQ-011 inst_valid  in  1  inst_word carries a fetched instruction this cycle.
REQ-012 inst_word  in  DATA_W  fetched instruction.
REQ-013 reg_addr  out  REG_AW  register-file read index.
REQ-014 reg_data  in  DATA_W  combinational register-file read data for reg_addr.
REQ-015 dump_valid  out  1  dump word available.
REQ-016 dump_ready  in  1  consumer accepts dump word.
REQ-017 dump_idx  out  REG_AW  register index of dump_data.
REQ-018 dump_data  out  DATA_W  dumped register value.
REQ-019 clk_cnt  out  CNT_W  cycles spent in RUN.
REQ-020 busy  out  1  high in RUN or DUMP.
REQ-021 done  out  1  high in DONE.
REQ-022 halt_seen  out  1  run ended on HALT_WORD.
REQ-023 timed_out  out  1  run ended on TIMEOUT.

Function
REQ-024 FSM states SHALL be IDLE, RUN, DUMP, DONE; start honoured only in IDLE and DONE, ignored in RUN/DUMP.
REQ-025 IDLE/DONE + start SHALL enter RUN next cycle, clearing clk_cnt, halt_seen, timed_out, dump_idx to 0.
REQ-026 In RUN clk_cnt SHALL increment by 1 per cycle, saturating at 2**CNT_W-1, frozen outside RUN.
REQ-027 RUN SHALL exit to DUMP on inst_valid && inst_word==HALT_WORD, setting halt_seen=1.
REQ-028 RUN SHALL exit to DUMP when clk_cnt==TIMEOUT-1 in that cycle (no halt), setting timed_out=1; clk_cnt then reads TIMEOUT.
REQ-029 Halt and timeout in the same cycle: halt wins; halt_seen=1, timed_out=0.
REQ-030 inst_word with inst_valid=0 SHALL never trigger halt.
REQ-031 reg_addr SHALL be 0 outside DUMP and dump_idx+1 (wrapping at REG_AW) inside DUMP.
REQ-032 On the RUN->DUMP transition edge dump_data SHALL load reg_data (index 0); dump_valid=1, dump_idx=0 from the first DUMP cycle.
REQ-033 dump_data/dump_idx SHALL be stable while dump_valid && !dump_ready.
REQ-034 On dump_valid && dump_ready with dump_idx<DUMP_N-1: dump_idx++ and dump_data loads reg_data, dump_valid stays 1 (one word/cycle sustained).
REQ-035 On accept of dump_idx==DUMP_N-1: dump_valid=0 next cycle, state DONE.
REQ-036 halt_seen/timed_out SHALL hold through DUMP and DONE until next start.
REQ-037 dump_ready outside DUMP SHALL have no effect.

Reset
REQ-038 RSTN_N low SHALL asynchronously force IDLE, clk_cnt=0, dump_valid=0, dump_idx=0, dump_data=0, busy=0, done=0, halt_seen=0, timed_out=0, aborting any run or dump.
REQ-039 After RSTN_N rises, first start SHALL be honoured on the first rising edge it is sampled.

Verification
REQ-040 start, HALT_WORD valid on RUN cycle 20 -> halt_seen=1, timed_out=0, clk_cnt=21, 10 dump words idx 0..9 matching register model, done=1.
REQ-041 start, no halt, TIMEOUT=500 -> DUMP entered with clk_cnt=500, timed_out=1, halt_seen=0.
REQ-042 HALT_WORD valid exactly in cycle clk_cnt==499 -> halt_seen=1, timed_out=0.
REQ-043 dump_ready toggled 1,0,0,1 randomly -> dump_data/dump_idx stable while stalled, no word lost or duplicated; dump_ready held 1 -> 10 words in 10 consecutive cycles.
REQ-044 RSTN_N pulsed low mid-DUMP at idx 4 -> immediate dump_valid=0, all flags 0, IDLE; later start runs cleanly from clk_cnt=0.
REQ-045 start during RUN and DUMP -> ignored; start in DONE -> flags cleared, new run begins.
